// File: rtl/tb_sram_mp.sv
// tb_sram_mp: multi-port bench SRAM. Several requesters share one word array
// through a round-robin arbiter. Each accepted access gets one response,
// READ_LATENCY cycles after the accepting edge. Responses come back in
// acceptance order. Accesses to addresses >= NUM_WORDS are flagged on err_o.
module tb_sram_mp #(
  parameter int unsigned NUM_PORTS    = 2,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned NUM_WORDS    = 32768,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned INIT_ZERO    = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o,
  output logic [NUM_PORTS-1:0]              err_o
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [DATA_WIDTH-1:0] INIT_VAL = (INIT_ZERO != 0) ? '0 : 'x;

  typedef struct packed {
    logic                  valid;
    logic [PW-1:0]         port;
    logic                  err;
    logic [DATA_WIDTH-1:0] data;
  } resp_t;

  // Bench-only storage. The time-0 fill models the zero-initialised array.
  logic [DATA_WIDTH-1:0] mem [NUM_WORDS] = '{default: INIT_VAL};

  logic [PW-1:0]           ptr_q;
  logic                    gnt_any;
  logic [PW-1:0]           gnt_idx;
  logic [PW-1:0]           cand;
  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic [NB-1:0]           sel_be;
  logic                    in_range;
  logic [IW-1:0]           idx;
  resp_t                   resp_in;
  resp_t                   pipe_q [READ_LATENCY];
  resp_t                   pipe_last;
  logic [NUM_PORTS*DATA_WIDTH-1:0] hold_q;

  // Round-robin search: first requester at or after the pointer, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    if (rst_ni) begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        cand = PW'((32'(ptr_q) + i) % NUM_PORTS);
        if (!gnt_any && req_i[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    gnt_o = NUM_PORTS'(gnt_any) << gnt_idx;
  end

  // Route the granted port's request to the array and build its response.
  always_comb begin
    sel_we    = we_i[gnt_idx];
    sel_addr  = addr_i[32'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_wdata = wdata_i[32'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    sel_be    = be_i[32'(gnt_idx)*NB +: NB];
    // Compare one bit wider so that NUM_WORDS == 2**ADDR_WIDTH cannot wrap to 0.
    in_range  = ({1'b0, sel_addr} < (ADDR_WIDTH+1)'(NUM_WORDS));
    idx       = sel_addr[IW-1:0];
    resp_in.valid = gnt_any;
    resp_in.port  = gnt_idx;
    resp_in.err   = !in_range;
    resp_in.data  = (in_range && !sel_we) ? mem[idx] : '0;
  end

  // Pointer moves past the granted port; it holds when nothing is granted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  // Byte-masked write commits at the accepting edge. Out-of-range writes are dropped.
  always_ff @(posedge clk_i) begin
    if (gnt_any && sel_we && in_range) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (sel_be[b]) mem[idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // Response shift pipeline. Reset flushes every in-flight entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < READ_LATENCY; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= resp_in;
      for (int unsigned s = 1; s < READ_LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  // Decode the pipeline's last stage to the owning port. Other ports show held data.
  always_comb begin
    pipe_last = pipe_q[READ_LATENCY-1];
    rvalid_o  = '0;
    err_o     = '0;
    rdata_o   = hold_q;
    if (pipe_last.valid) begin
      rvalid_o[pipe_last.port] = 1'b1;
      err_o[pipe_last.port]    = pipe_last.err;
      rdata_o[32'(pipe_last.port)*DATA_WIDTH +: DATA_WIDTH] = pipe_last.data;
    end
  end

  // Capture what each port currently shows, so rdata holds between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q <= '0;
    end else begin
      hold_q <= rdata_o;
    end
  end

endmodule
